// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage of the 5-stage pipeline. Owns the PC register,
//   the icache request and the IF/ID latch. Consumes stall/redirect/halt
//   decisions from the hazard/decode logic and a whole-pipeline freeze from
//   the MEM stage. The icache address is kept stable across a miss: a
//   redirect arriving mid-miss is parked in pend_pc and applied on the edge
//   where the in-flight fetch finally hits.
//
// Ports
//   CLK          in   1  clock, rising edge
//   nRST         in   1  asynchronous active-low reset
//   ihit         in   1  icache returned imemload for imemaddr this cycle
//   imemload     in  32  instruction word, valid when ihit=1
//   hazard       in   1  decode must stall (hold IF/ID and PC)
//   redirect     in   1  branch taken or jump in decode
//   redirect_pc  in  32  redirect target
//   halt         in   1  decode-stage instruction is HALT
//   mem_busy     in   1  MEM stage waiting on dcache, freezes everything
//   imemREN      out  1  icache read enable (low once halted)
//   imemaddr     out 32  icache address (= PC register)
//   ifid_instr   out 32  latched instruction
//   ifid_npc     out 32  latched PC+4 of that instruction
//   ifid_valid   out  1  latch holds a real instruction (0 = bubble)

module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h00000000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        hazard,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  input  logic        mem_busy,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_npc,
  output logic        ifid_valid
);

  logic [31:0] pc_q,     pc_d;
  logic        pend_q,   pend_d;
  logic [31:0] pendPc_q, pendPc_d;
  logic        halted_q, halted_d;
  logic [31:0] instr_q,  instr_d;
  logic [31:0] npc_q,    npc_d;
  logic        valid_q,  valid_d;

  logic [31:0] pcPlus4;

  assign pcPlus4    = pc_q + 32'd4;
  assign imemaddr   = pc_q;
  assign imemREN    = !halted_q;
  assign ifid_instr = instr_q;
  assign ifid_npc   = npc_q;
  assign ifid_valid = valid_q;

  // Next-state selection. The branches are a strict priority chain: the
  // first condition that matches decides the whole update for this cycle.
  always_comb begin
    pc_d     = pc_q;
    pend_d   = pend_q;
    pendPc_d = pendPc_q;
    halted_d = halted_q;
    instr_d  = instr_q;
    npc_d    = npc_q;
    valid_d  = valid_q;

    if (mem_busy) begin
      // Whole pipeline frozen; decode re-presents its decisions next cycle.
    end else if (halted_q) begin
      instr_d = 32'h0;
      npc_d   = 32'h0;
      valid_d = 1'b0;
    end else if (halt && !hazard) begin
      halted_d = 1'b1;
      pend_d   = 1'b0;
      instr_d  = 32'h0;
      npc_d    = 32'h0;
      valid_d  = 1'b0;
    end else if (pend_q) begin
      // Waiting for the in-flight wrong-path fetch to finish; its word is
      // thrown away and only then does the address move to the target.
      instr_d = 32'h0;
      npc_d   = 32'h0;
      valid_d = 1'b0;
      if (ihit) begin
        pc_d   = pendPc_q;
        pend_d = 1'b0;
      end
    end else if (redirect && !hazard) begin
      instr_d = 32'h0;
      npc_d   = 32'h0;
      valid_d = 1'b0;
      if (ihit) begin
        pc_d = redirect_pc;
      end else begin
        pend_d   = 1'b1;
        pendPc_d = redirect_pc;
      end
    end else if (hazard) begin
      // Hold PC and latch; any word returned now is simply fetched again.
    end else if (ihit) begin
      instr_d = imemload;
      npc_d   = pcPlus4;
      valid_d = 1'b1;
      pc_d    = pcPlus4;
    end else begin
      instr_d = 32'h0;
      npc_d   = 32'h0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc_q     <= PC_INIT;
      pend_q   <= 1'b0;
      pendPc_q <= 32'h0;
      halted_q <= 1'b0;
      instr_q  <= 32'h0;
      npc_q    <= 32'h0;
      valid_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      pend_q   <= pend_d;
      pendPc_q <= pendPc_d;
      halted_q <= halted_d;
      instr_q  <= instr_d;
      npc_q    <= npc_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage pipeline: owns the PC register and the IF/ID pipeline latch, and is the direct upstream neighbour of the hazard/decode logic. It consumes the hazard unit's stall and redirect decisions (load-use stall, taken branch, jump) and produces the fetched instruction for decode. It also owns the icache request (address and read enable). It keeps the request address stable across icache misses, deferring any redirect that arrives mid-miss until the in-flight fetch completes.

## Interface
Parameters:
- PC_INIT, 32'h00000000, PC value loaded on reset.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- nRST  in  1  asynchronous, active-low reset.
- ihit  in  1  icache returned imemload for imemaddr this cycle.
- imemload  in  32  instruction word from icache, valid when ihit=1.
- hazard  in  1  hazard unit: decode-stage instruction must stall (hold IF/ID).
- redirect  in  1  hazard unit: branch taken or jump in decode (branch|jump).
- redirect_pc  in  32  target for redirect, valid when redirect=1.
- halt  in  1  decode-stage instruction is HALT.
- mem_busy  in  1  MEM stage waiting on dcache (dmem request && !dhit); freezes whole pipeline.
- imemREN  out  1  icache read enable.
- imemaddr  out  32  icache address, equals PC register.
- ifid_instr  out  32  latched instruction to decode.
- ifid_npc  out  32  latched PC+4 of that instruction.
- ifid_valid  out  1  latch holds a real instruction (0 = bubble).

## Operation
State: pc[31:0], pend (1 bit), pend_pc[31:0], halted (1 bit), IF/ID latch (instr, npc, valid).
- imemaddr = pc; imemREN = !halted. PC+4 wraps modulo 2^32.
- "Bubble" means instr=32'h0, npc=32'h0, valid=0.
- Per-cycle update, first matching rule wins:
  1. mem_busy=1: hold all state (pc, pend, pend_pc, halted, latch). Redirect/halt/ihit ignored; decode re-presents them next cycle.
  2. halted=1: hold pc; latch loads bubble; ihit ignored.
  3. halt=1 and hazard=0: halted<=1, pend<=0, latch loads bubble, pc held.
  4. pend=1: if ihit, pc<=pend_pc, pend<=0, fetched word discarded; latch loads bubble either way.
  5. redirect=1 and hazard=0: latch loads bubble (flush wrong-path word). If ihit, pc<=redirect_pc. Else pend<=1, pend_pc<=redirect_pc, pc held (no address change mid-miss).
  6. hazard=1: hold pc and latch; a concurrent ihit word is dropped and refetched.
  7. ihit=1: latch<=(imemload, pc+4, 1); pc<=pc+4.
  8. otherwise (miss): latch loads bubble; pc held.
- redirect while hazard=1 is ignored (branch operands not yet final).
- halted clears only on reset.

## Timing
- Reset (async, nRST=0): pc=PC_INIT, pend=0, pend_pc=0, halted=0, latch bubble. Thus imemREN=1, imemaddr=PC_INIT, ifid_*=0.
- Reset asserted mid-miss or with pend=1: all state returns to reset values immediately. No pending redirect survives.
- Fetch latency: instruction appears on ifid_* the cycle after the edge on which ihit=1.
- Redirect with ihit: target fetched starting next cycle. Exactly one bubble enters decode.
- Redirect during miss: pc stays until ihit. That ihit edge loads pend_pc, and the target fetch starts the following cycle. Decode sees bubbles for the whole interval.
- imemaddr changes only on an edge where ihit=1 (rules 4, 5, 7) or on reset.

## Test plan
- Reset: nRST=0 with PC_INIT=0 -> imemaddr=0, imemREN=1, ifid_valid=0, ifid_instr=0; release, ihit=1 every cycle with words A,B,C -> ifid shows A/npc 4, B/npc 8, C/npc 12 on consecutive cycles.
- Miss: ihit=0 for 3 cycles at pc=8 -> imemaddr stays 8, ifid_valid=0 those cycles; ihit=1 -> word latched, imemaddr=12.
- Redirect with hit: pc=0x10, redirect=1, redirect_pc=0x40, ihit=1, hazard=0 -> next cycle imemaddr=0x40, ifid_valid=0.
- Redirect during miss: pc=0x10, ihit=0, redirect=1 to 0x80 -> imemaddr holds 0x10 until ihit. On that ihit, the word is discarded, imemaddr becomes 0x80 and ifid_valid stays 0. Next ihit latches the 0x80 word with npc 0x84.
- Stalls: hazard=1 with ihit=1 for 2 cycles -> pc and ifid_* unchanged. Redirect=1 during hazard -> ignored. mem_busy=1 with redirect=1 and ihit=1 -> all outputs frozen.
- Halt: halt=1, hazard=0, mem_busy=0 -> imemREN=0 next cycle, pc frozen, ifid bubble, further ihit ignored; nRST pulse -> imemREN=1, imemaddr=PC_INIT.
